imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the fetch path. Fetch only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and parses a 16-bit little-endian word-count header.
- Assembles the following bytes into 32-bit little-endian instructions and issues one registered write per word to the instruction-memory write port.
- Holds the core in reset (core_hold) from load start until completion, so fetch begins at PC 0 on a fully loaded image.

Parameters:
- DEPTH, 256: number of 32-bit words in instruction memory.
- ADDR_W, 8: word-index width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  word index being written (memory word index, i.e. byte address >> 2).
- wr_data  output  32  instruction word.
- core_hold  output  1  high while a load is in progress; ORed into the core's reset by the top level.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky length error; cleared by the next accepted start or by reset.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; in_ready, wr_en, core_hold, done, err = 0; wr_addr = 0; wr_data = 0; byte counter, word counter and length register cleared. A reset mid-load abandons the load; words already written remain in memory.
- States: IDLE, LEN_LO, LEN_HI, DATA, FIN.
- IDLE: in_ready=0. On start: clear err, set core_hold=1, go to LEN_LO. A start pulse in any other state is ignored.
- LEN_LO: in_ready=1. On a transfer, latch len[7:0] and go to LEN_HI.
- LEN_HI: in_ready=1. On a transfer, latch len[15:8]. Next state:
  - len==0: FIN.
  - len>DEPTH: set err=1, drop core_hold, return to IDLE; no writes are issued.
  - otherwise: DATA, with byte index=0 and word counter=0.
- DATA: in_ready=1.
  - Each transfer stores the byte into lane [8*idx+7:8*idx] of the assembly register, then idx increments mod 4. The first byte received is bits [7:0].
  - On the transfer with idx==3, in the next cycle: wr_en=1, wr_data = assembled word including this byte, wr_addr = word counter. The word counter then increments.
  - If the incremented counter equals len, go to FIN; otherwise stay in DATA.
  - in_ready stays high during the write cycle, so a new byte may be accepted in the same cycle wr_en is high. Sustained throughput is one byte per cycle.
- wr_en is registered and high for exactly one cycle per word. wr_addr and wr_data hold their last value when wr_en=0.
- FIN: in_ready=0. Wait one cycle so the final write completes, then pulse done=1 for one cycle, drop core_hold, and go to IDLE.
- Stream stalls: in_valid=0 in any receiving state holds all state; there is no timeout.
- Word counter is ADDR_W+1 bits wide, so len==DEPTH completes without wrap-around.
- Bytes offered while in IDLE or FIN are not accepted (in_ready=0).

Test Plan:
- Reset, then start + bytes 02 00, 33 81 30 00, 33 02 53 00 -> wr_en pulses twice: addr 0 data 0x00308133, addr 1 data 0x00530233. done pulses 1 cycle after the second write; core_hold high from the cycle after start until done.
- Header 00 00 -> no wr_en, done pulses, err=0, back in IDLE.
- Header 01 01 (len 257 > 256) -> err=1, core_hold=0, no writes, IDLE. Next start clears err.
- 3-word load with in_valid toggled randomly -> same three writes at addrs 0..2 with correct data, no duplicate or skipped strobes.
- Full load, len 256 (header 00 01) -> 256 writes at addrs 0..255, last at 255, done asserted, no write to addr 0 after wrap.
- Assert reset after 2 of 4 words -> all outputs 0 immediately (asynchronously); a subsequent start + 1-word load writes addr 0 correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a 16-bit LE word count, then packs the
// byte stream into 32-bit LE words and writes them from index 0 upward.
// The core is held in reset for the whole load.
module imem_loader #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_core_hold,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    logic [2:0]        r_state,     w_state_nxt;
    logic [15:0]       r_len,       w_len_nxt;
    logic [1:0]        r_idx,       w_idx_nxt;
    logic [CNT_W-1:0]  r_wcnt,      w_wcnt_nxt;
    logic [31:0]       r_asm,       w_asm_nxt;
    logic              r_in_ready,  w_in_ready_nxt;
    logic              r_wr_en,     w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr,   w_wr_addr_nxt;
    logic [31:0]       r_wr_data,   w_wr_data_nxt;
    logic              r_core_hold, w_core_hold_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_err,       w_err_nxt;

    logic              w_xfer;
    logic [15:0]       w_len_full;
    logic [31:0]       w_asm_ins;
    logic [CNT_W-1:0]  w_wcnt_inc;

    assign w_xfer     = i_in_valid && r_in_ready;
    assign w_len_full = {i_in_data, r_len[7:0]};
    assign w_wcnt_inc = r_wcnt + CNT_W'(1);

    // Current assembly register with the incoming byte dropped into its lane
    always_comb begin
        w_asm_ins = r_asm;
        w_asm_ins[{r_idx, 3'b000} +: 8] = i_in_data;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_idx_nxt       = r_idx;
        w_wcnt_nxt      = r_wcnt;
        w_asm_nxt       = r_asm;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_core_hold_nxt = r_core_hold;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_err_nxt       = 1'b0;
                    w_core_hold_nxt = 1'b1;
                    w_state_nxt     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    w_len_nxt[7:0] = i_in_data;
                    w_state_nxt    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    w_len_nxt = w_len_full;
                    if (w_len_full == 16'd0) begin
                        w_state_nxt = S_FIN;
                    end else if ({1'b0, w_len_full} > 17'(DEPTH)) begin
                        w_err_nxt       = 1'b1;
                        w_core_hold_nxt = 1'b0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_idx_nxt   = 2'd0;
                        w_wcnt_nxt  = '0;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_asm_nxt = w_asm_ins;
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_data_nxt = w_asm_ins;
                        w_wr_addr_nxt = r_wcnt[ADDR_W-1:0];
                        w_wcnt_nxt    = w_wcnt_inc;
                        if (16'(w_wcnt_inc) == r_len) begin
                            w_state_nxt = S_FIN;
                        end
                    end
                end
            end
            S_FIN: begin
                w_done_nxt      = 1'b1;
                w_core_hold_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_core_hold_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == S_LEN_LO) || (w_state_nxt == S_LEN_HI) ||
                         (w_state_nxt == S_DATA);
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_wcnt      <= '0;
            r_asm       <= '0;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_core_hold <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_asm       <= w_asm_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_core_hold <= w_core_hold_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_core_hold = r_core_hold;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word assembly, length
// error, stalled stream, full-depth load and asynchronous reset mid-load.
module tb_imem_loader;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              core_hold;
    logic              done;
    logic              err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [ADDR_W-1:0] q_addr[$];
    logic [31:0]       q_data[$];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_core_hold (core_hold),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // Log every write strobe, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] mk_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b + 8'h03, b ^ 8'h5a, ~b, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Offer one byte; returns one step after the edge on which it transferred
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        t = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_byte(w[7:0], gaps);
        send_byte(w[15:8], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[31:24], gaps);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 20) begin
            step();
            t++;
        end
        chk(tag, 32'(done), 32'd1);
        chk({tag, "_hold"}, 32'(core_hold), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int n);
        chk({tag, "_nwr"}, 32'(q_addr.size()), 32'(n));
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(q_addr[i]), 32'(i));
            chk({tag, "_data"}, q_data[i], mk_word(i));
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] w1;

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_wren",  32'(wr_en), 32'd0);
        chk("rst_addr",  32'(wr_addr), 32'd0);
        chk("rst_data",  wr_data, 32'd0);
        chk("rst_hold",  32'(core_hold), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);

        // Bytes offered in IDLE are refused
        in_valid = 1'b1;
        in_data  = 8'hff;
        step();
        chk("idle_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Two-word load with exact timing
        clear_log();
        do_start();
        chk("t1_hold", 32'(core_hold), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        w0 = 32'h00308133;
        w1 = 32'h00530233;
        send_word(w0, 1'b0);
        chk("t1_w0_en", 32'(wr_en), 32'd1);
        chk("t1_w0_addr", 32'(wr_addr), 32'd0);
        chk("t1_w0_data", wr_data, 32'h00308133);
        send_word(w1, 1'b0);
        chk("t1_w1_en", 32'(wr_en), 32'd1);
        chk("t1_w1_addr", 32'(wr_addr), 32'd1);
        chk("t1_w1_data", wr_data, 32'h00530233);
        chk("t1_fin_done", 32'(done), 32'd0);
        chk("t1_fin_hold", 32'(core_hold), 32'd1);
        chk("t1_fin_ready", 32'(in_ready), 32'd0);
        step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_hold", 32'(core_hold), 32'd0);
        chk("t1_done_wren", 32'(wr_en), 32'd0);
        chk("t1_hold_addr", 32'(wr_addr), 32'd1);
        chk("t1_hold_data", wr_data, 32'h00530233);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_nwr", 32'(q_addr.size()), 32'd2);

        // Zero-length header
        clear_log();
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_done("t2_done");
        chk("t2_err", 32'(err), 32'd0);
        step();
        chk("t2_idle_ready", 32'(in_ready), 32'd0);
        chk("t2_nwr", 32'(q_addr.size()), 32'd0);

        // Length 257 exceeds depth
        clear_log();
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_hold", 32'(core_hold), 32'd0);
        chk("t3_ready", 32'(in_ready), 32'd0);
        repeat (3) step();
        chk("t3_err_sticky", 32'(err), 32'd1);
        chk("t3_nwr", 32'(q_addr.size()), 32'd0);
        do_start();
        chk("t3_err_clr", 32'(err), 32'd0);
        chk("t3_restart_hold", 32'(core_hold), 32'd1);

        // Three words with a stalling stream (continues the pending start)
        clear_log();
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) send_word(mk_word(i), 1'b1);
        wait_done("t4_done");
        check_writes("t4", 3);

        // Full-depth load
        clear_log();
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 256; i++) send_word(mk_word(i), 1'b0);
        wait_done("t5_done");
        check_writes("t5", 256);
        if (q_addr.size() > 0)
            chk("t5_last_addr", 32'(q_addr[q_addr.size()-1]), 32'd255);

        // Asynchronous reset after two of four words
        clear_log();
        do_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(mk_word(0), 1'b0);
        send_word(mk_word(1), 1'b0);
        chk("t6_pre_hold", 32'(core_hold), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(in_ready), 32'd0);
        chk("t6_rst_wren", 32'(wr_en), 32'd0);
        chk("t6_rst_addr", 32'(wr_addr), 32'd0);
        chk("t6_rst_data", wr_data, 32'd0);
        chk("t6_rst_hold", 32'(core_hold), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        step();
        rst = 1'b0;
        step();
        clear_log();
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(mk_word(0), 1'b0);
        wait_done("t6_done");
        check_writes("t6", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
